// File: rtl/mul_shift_add_ctrl.sv
// Iterative unsigned shift-and-add multiplier sequencer. It drives an external
// combinational adder and returns the low n bits of the product.
module mul_shift_add_ctrl #(
    parameter int n  = 64,
    parameter int CW = $clog2(n) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [n-1:0]  multiplicand,
    input  logic [n-1:0]  multiplier,
    output logic [n-1:0]  add_a,
    output logic [n-1:0]  add_b,
    output logic          add_cin,
    input  logic [n-1:0]  add_sum,
    output logic          busy,
    output logic          done,
    output logic [n-1:0]  product,
    output logic [CW-1:0] steps
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state;
    logic [n-1:0]   acc;
    logic [n-1:0]   mcand_r;
    logic [n-1:0]   mplier_r;

    // RUN ends once no set multiplier bits remain above bit 0, or on the last bit.
    function automatic logic run_last(input logic [n-1:0] mplier, input logic [CW-1:0] cnt);
        logic no_more_bits;
        no_more_bits = ((mplier >> 1) == '0);
        return no_more_bits || (cnt == CW'(n - 1));
    endfunction

    function automatic logic [n-1:0] partial_term(input logic [n-1:0] mcand, input logic bit0);
        return bit0 ? mcand : '0;
    endfunction

    assign add_a   = acc;
    assign add_b   = partial_term(mcand_r, mplier_r[0]);
    assign add_cin = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            product  <= '0;
            steps    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc      <= '0;
                        mcand_r  <= multiplicand;
                        mplier_r <= multiplier;
                        steps    <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc      <= add_sum;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    steps    <= steps + 1'b1;
                    if (run_last(mplier_r, steps)) begin
                        // The final partial sum is already on add_sum this cycle.
                        product <= add_sum;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
